// File: rtl/tinyqv_data_arbiter.sv
// Two-master arbiter for the tinyqv_mem_ctrl data port with bounded continue-bursts.
// Optional: define TINYQV_ARB_ROUND_ROBIN_EN for alternating tie-break (default: A wins ties).
module tinyqv_data_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [24:0] a_addr,
  input  logic [1:0]  a_write_n,
  input  logic [1:0]  a_read_n,
  input  logic [31:0] a_wdata,
  input  logic        a_continue,
  input  logic [24:0] b_addr,
  input  logic [1:0]  b_write_n,
  input  logic [1:0]  b_read_n,
  input  logic [31:0] b_wdata,
  input  logic        b_continue,
  output logic        a_ready,
  output logic        b_ready,
  output logic [31:0] a_rdata,
  output logic [31:0] b_rdata,
  output logic [24:0] mem_addr,
  output logic [1:0]  mem_write_n,
  output logic [1:0]  mem_read_n,
  output logic [31:0] mem_wdata,
  output logic        mem_continue,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        grant_a,
  output logic        grant_b
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t           state;
  logic [CNT_W-1:0] burst_cnt;
  logic             last_owner_b;
  logic             a_req, b_req, at_limit;
  logic             a_cont_eff, b_cont_eff;
  logic             tie_to_b;

  assign a_req    = (a_read_n != 2'b11) || (a_write_n != 2'b11);
  assign b_req    = (b_read_n != 2'b11) || (b_write_n != 2'b11);
  assign at_limit = (burst_cnt == CNT_LAST);

  // Chaining is refused for the transaction that would exceed the burst while the other side waits.
  assign a_cont_eff = a_continue && !(b_req && at_limit);
  assign b_cont_eff = b_continue && !(a_req && at_limit);

`ifdef TINYQV_ARB_ROUND_ROBIN_EN
  assign tie_to_b = !last_owner_b;
`else
  logic unused_last_owner;
  assign tie_to_b          = 1'b0;
  assign unused_last_owner = last_owner_b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_a      <= 1'b0;
      grant_b      <= 1'b0;
      burst_cnt    <= '0;
      last_owner_b <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (a_req && !(b_req && tie_to_b)) begin
            state   <= OWN_A;
            grant_a <= 1'b1;
          end else if (b_req) begin
            state   <= OWN_B;
            grant_b <= 1'b1;
          end
        end
        OWN_A: begin
          if (mem_ready) begin
            if (a_cont_eff) begin
              if (!at_limit) burst_cnt <= burst_cnt + 1'b1;
            end else begin
              state        <= IDLE;
              grant_a      <= 1'b0;
              burst_cnt    <= '0;
              last_owner_b <= 1'b0;
            end
          end
        end
        OWN_B: begin
          if (mem_ready) begin
            if (b_cont_eff) begin
              if (!at_limit) burst_cnt <= burst_cnt + 1'b1;
            end else begin
              state        <= IDLE;
              grant_b      <= 1'b0;
              burst_cnt    <= '0;
              last_owner_b <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_a <= 1'b0;
          grant_b <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr     = '0;
    mem_write_n  = 2'b11;
    mem_read_n   = 2'b11;
    mem_wdata    = '0;
    mem_continue = 1'b0;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    if (grant_a) begin
      mem_addr     = a_addr;
      mem_write_n  = a_write_n;
      mem_read_n   = a_read_n;
      mem_wdata    = a_wdata;
      mem_continue = a_cont_eff;
      a_ready      = mem_ready;
    end else if (grant_b) begin
      mem_addr     = b_addr;
      mem_write_n  = b_write_n;
      mem_read_n   = b_read_n;
      mem_wdata    = b_wdata;
      mem_continue = b_cont_eff;
      b_ready      = mem_ready;
    end
  end

  // Read data is shared; each master qualifies it with its own ready.
  assign a_rdata = mem_rdata;
  assign b_rdata = mem_rdata;

endmodule

// File: tb/tb_tinyqv_data_arbiter.sv
// Directed vector bench for tinyqv_data_arbiter (MAX_BURST=4), plus a burst-handoff sequence.
module tb_tinyqv_data_arbiter;

  localparam logic [1:0]  NO = 2'b11;
  localparam logic [31:0] AW = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] a_addr, b_addr;
  logic [1:0]  a_write_n, a_read_n, b_write_n, b_read_n;
  logic [31:0] a_wdata, b_wdata;
  logic        a_continue, b_continue;
  logic        a_ready, b_ready;
  logic [31:0] a_rdata, b_rdata;
  logic [24:0] mem_addr;
  logic [1:0]  mem_write_n, mem_read_n;
  logic [31:0] mem_wdata;
  logic        mem_continue, mem_ready;
  logic [31:0] mem_rdata;
  logic        grant_a, grant_b;

  always #5 clk = ~clk;

  tinyqv_data_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .a_addr(a_addr), .a_write_n(a_write_n), .a_read_n(a_read_n), .a_wdata(a_wdata), .a_continue(a_continue),
    .b_addr(b_addr), .b_write_n(b_write_n), .b_read_n(b_read_n), .b_wdata(b_wdata), .b_continue(b_continue),
    .a_ready(a_ready), .b_ready(b_ready), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_write_n(mem_write_n), .mem_read_n(mem_read_n), .mem_wdata(mem_wdata),
    .mem_continue(mem_continue), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_a(grant_a), .grant_b(grant_b)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  arn, awn;
    logic [24:0] aaddr;
    logic        acont;
    logic [1:0]  brn, bwn;
    logic [24:0] baddr;
    logic [31:0] bwd;
    logic        bcont;
    logic        mrdy;
    logic [31:0] mrd;
    logic        ega, egb;
    logic [1:0]  ern, ewn;
    logic [24:0] eaddr;
    logic [31:0] ewd;
    logic        econt, ear, ebr;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;
  int   nvec = 0;
  int   nerr = 0;

  task automatic st(input logic r, input logic [1:0] arn, input logic [1:0] awn, input logic [24:0] aaddr,
                    input logic acont, input logic [1:0] brn, input logic [1:0] bwn, input logic [24:0] baddr,
                    input logic [31:0] bwd, input logic bcont, input logic mrdy, input logic [31:0] mrd);
    cur.rst = r; cur.arn = arn; cur.awn = awn; cur.aaddr = aaddr; cur.acont = acont;
    cur.brn = brn; cur.bwn = bwn; cur.baddr = baddr; cur.bwd = bwd; cur.bcont = bcont;
    cur.mrdy = mrdy; cur.mrd = mrd;
  endtask

  task automatic e_idle();
    cur.ega = 0; cur.egb = 0; cur.ern = NO; cur.ewn = NO; cur.eaddr = '0; cur.ewd = '0;
    cur.econt = 0; cur.ear = 0; cur.ebr = 0;
    vecs.push_back(cur);
  endtask

  task automatic e_a(input logic econt, input logic ear);
    cur.ega = 1; cur.egb = 0; cur.ern = cur.arn; cur.ewn = cur.awn; cur.eaddr = cur.aaddr; cur.ewd = AW;
    cur.econt = econt; cur.ear = ear; cur.ebr = 0;
    vecs.push_back(cur);
  endtask

  task automatic e_b(input logic econt, input logic ebr);
    cur.ega = 0; cur.egb = 1; cur.ern = cur.brn; cur.ewn = cur.bwn; cur.eaddr = cur.baddr; cur.ewd = cur.bwd;
    cur.econt = econt; cur.ear = 0; cur.ebr = ebr;
    vecs.push_back(cur);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; a_read_n = v.arn; a_write_n = v.awn; a_addr = v.aaddr; a_continue = v.acont;
    b_read_n = v.brn; b_write_n = v.bwn; b_addr = v.baddr; b_wdata = v.bwd; b_continue = v.bcont;
    mem_ready = v.mrdy; mem_rdata = v.mrd;
  endtask

  task automatic check(input string name, input logic ok, input logic [63:0] got, input logic [63:0] want);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  initial begin
    int   na;
    logic got_b, drop;
    vec_t v;

    rst = 1; a_read_n = NO; a_write_n = NO; a_addr = '0; a_wdata = AW; a_continue = 0;
    b_read_n = NO; b_write_n = NO; b_addr = '0; b_wdata = '0; b_continue = 0;
    mem_ready = 0; mem_rdata = '0;

    // reset, then idle
    st(1, NO, NO, 0, 0, NO, NO, 0, 0, 0, 0, 0); e_idle(); e_idle();
    st(0, NO, NO, 0, 0, NO, NO, 0, 0, 0, 0, 0); e_idle();
    // simultaneous requests: A read 0x200, B byte write 0x300
    st(0, 2'b10, NO, 25'h200, 0, NO, 2'b00, 25'h300, 32'hA5, 0, 0, 0);            e_idle();
    st(0, 2'b10, NO, 25'h200, 0, NO, 2'b00, 25'h300, 32'hA5, 0, 1, 32'h11);        e_a(0, 1);
    st(0, 2'b10, NO, 25'h200, 0, NO, 2'b00, 25'h300, 32'hA5, 0, 0, 0);            e_idle();
    st(0, 2'b10, NO, 25'h200, 0, NO, 2'b00, 25'h300, 32'hA5, 0, 1, 32'h22);
`ifdef TINYQV_ARB_ROUND_ROBIN_EN
    e_b(0, 1);
`else
    e_a(0, 1);
`endif
    st(0, 2'b10, NO, 25'h200, 0, NO, 2'b00, 25'h300, 32'hA5, 0, 0, 0);            e_idle();
    st(0, 2'b10, NO, 25'h200, 0, NO, 2'b00, 25'h300, 32'hA5, 0, 1, 32'h33);        e_a(0, 1);
    // B alone
    st(0, NO, NO, 0, 0, NO, 2'b00, 25'h300, 32'hA5, 0, 0, 0);                      e_idle();
    e_b(0, 0);
    st(0, NO, NO, 0, 0, NO, 2'b00, 25'h300, 32'hA5, 0, 1, 32'h44);                 e_b(0, 1);
    st(0, NO, NO, 0, 0, NO, NO, 0, 0, 0, 0, 0);                                     e_idle();
    // single A 32b read of 0x000100
    st(0, 2'b10, NO, 25'h100, 0, NO, NO, 0, 0, 0, 0, 0);                           e_idle();
    e_a(0, 0);
    st(0, 2'b10, NO, 25'h100, 0, NO, NO, 0, 0, 0, 1, 32'hDEADBEEF);                 e_a(0, 1);
    st(0, NO, NO, 0, 0, NO, NO, 0, 0, 0, 0, 0);                                     e_idle();
    // A chains with B waiting: fourth transaction must see continue forced low
    st(0, 2'b10, NO, 25'h1000, 1, NO, NO, 0, 0, 0, 0, 0);                          e_idle();
    st(0, 2'b10, NO, 25'h1000, 1, NO, 2'b00, 25'h400, 32'hA5, 0, 1, 32'h1000);     e_a(1, 1);
    st(0, 2'b10, NO, 25'h1004, 1, NO, 2'b00, 25'h400, 32'hA5, 0, 1, 32'h1004);     e_a(1, 1);
    st(0, 2'b10, NO, 25'h1008, 1, NO, 2'b00, 25'h400, 32'hA5, 0, 1, 32'h1008);     e_a(1, 1);
    st(0, 2'b10, NO, 25'h100C, 1, NO, 2'b00, 25'h400, 32'hA5, 0, 0, 0);            e_a(0, 0);
    st(0, 2'b10, NO, 25'h100C, 1, NO, 2'b00, 25'h400, 32'hA5, 0, 1, 32'h100C);     e_a(0, 1);
    st(0, NO, NO, 0, 0, NO, 2'b00, 25'h400, 32'hA5, 0, 0, 0);                      e_idle();
    e_b(0, 0);
    st(0, NO, NO, 0, 0, NO, 2'b00, 25'h400, 32'hA5, 0, 1, 32'h55);                 e_b(0, 1);
    st(0, NO, NO, 0, 0, NO, NO, 0, 0, 0, 0, 0);                                     e_idle();
    // B bursts alone: counter saturates, continue stays high; then A arrives at the limit
    st(0, NO, NO, 0, 0, 2'b01, NO, 25'h500, 0, 1, 0, 0);                           e_idle();
    for (int i = 0; i < 6; i++) begin
      st(0, NO, NO, 0, 0, 2'b01, NO, 25'h500, 0, 1, 1, 32'(i));                    e_b(1, 1);
    end
    st(0, 2'b10, NO, 25'h600, 0, 2'b01, NO, 25'h500, 0, 1, 0, 0);                  e_b(0, 0);
    st(0, 2'b10, NO, 25'h600, 0, 2'b01, NO, 25'h500, 0, 1, 1, 32'h66);             e_b(0, 1);
    st(0, 2'b10, NO, 25'h600, 0, NO, NO, 0, 0, 0, 0, 0);                           e_idle();
    st(0, 2'b10, NO, 25'h600, 0, NO, NO, 0, 0, 0, 1, 32'h77);                      e_a(0, 1);
    st(0, NO, NO, 0, 0, NO, NO, 0, 0, 0, 0, 0);                                     e_idle();
    // reset while B owns mid-read
    st(0, NO, NO, 0, 0, 2'b10, NO, 25'h700, 0, 0, 0, 0);                           e_idle();
    e_b(0, 0);
    st(1, NO, NO, 0, 0, 2'b10, NO, 25'h700, 0, 0, 0, 0);                           e_b(0, 0);
    st(0, NO, NO, 0, 0, NO, NO, 0, 0, 0, 1, 32'h88);                                e_idle();

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      drive(v);
      #1;
      nvec++;
      if ({grant_a, grant_b, mem_read_n, mem_write_n, mem_addr, mem_wdata, mem_continue, a_ready, b_ready,
           a_rdata, b_rdata} !==
          {v.ega, v.egb, v.ern, v.ewn, v.eaddr, v.ewd, v.econt, v.ear, v.ebr, v.mrd, v.mrd}) begin
        nerr++;
        $display("FAIL vec %0d: got ga=%b gb=%b rn=%b wn=%b addr=%h wd=%h cont=%b ar=%b br=%b ard=%h brd=%h; want ga=%b gb=%b rn=%b wn=%b addr=%h wd=%h cont=%b ar=%b br=%b rd=%h",
                 i, grant_a, grant_b, mem_read_n, mem_write_n, mem_addr, mem_wdata, mem_continue, a_ready,
                 b_ready, a_rdata, b_rdata, v.ega, v.egb, v.ern, v.ewn, v.eaddr, v.ewd, v.econt, v.ear,
                 v.ebr, v.mrd);
      end
    end

    // Handoff: A keeps chaining until it sees its continue refused, then B must be granted.
    a_read_n = 2'b10; a_addr = 25'h800; a_continue = 1;
    b_write_n = 2'b00; b_addr = 25'h900; b_wdata = 32'hA5;
    mem_ready = 1; mem_rdata = '0;
    na = 0; got_b = 0; drop = 0;
    for (int c = 0; c < 30 && !got_b; c++) begin
      @(negedge clk);
      if (drop) begin a_read_n = NO; a_continue = 0; end
      #1;
      if (grant_b) got_b = 1;
      else if (grant_a && a_ready) begin
        na++;
        if (!mem_continue) drop = 1;
      end
    end
    check("handoff_grant_b", got_b == 1'b1, 64'(got_b), 64'd1);
    check("handoff_a_txns", na == 4, 64'(na), 64'd4);
    check("handoff_b_write", {mem_write_n, mem_wdata, mem_addr, b_ready, a_ready} ===
          {2'b00, 32'hA5, 25'h900, 1'b1, 1'b0},
          64'({mem_write_n, mem_wdata, mem_addr, b_ready, a_ready}),
          64'({2'b00, 32'hA5, 25'h900, 1'b1, 1'b0}));

    @(negedge clk);
    b_write_n = NO; mem_ready = 0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
